// File: rtl/mips_hazard_ctrl.sv
// mips_hazard_ctrl: load-use / MDU interlock stall and taken-branch flush control with a saturating stall counter
module mips_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int MDU_LAT    = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_ex,
  input  logic [REG_AW-1:0] rt_ex,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              uses_rs_id,
  input  logic              uses_rt_id,
  input  logic              mdu_start_ex,
  input  logic              mdu_use_id,
  input  logic              branch_taken_id,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              stall,
  output logic              if_id_flush,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cycles
);
  logic [3:0] ld_cnt_q, ld_cnt_d;
  logic [5:0] mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic lu_hit, mdu_hit, hazard;
  always_comb begin
    lu_hit = mem_read_ex && rt_ex != '0 &&
             ((uses_rs_id && rt_ex == rs_id) || (uses_rt_id && rt_ex == rt_id));
    mdu_busy = !reset && mdu_cnt_q != '0;
    mdu_hit = mdu_use_id && mdu_busy;
    hazard = lu_hit || ld_cnt_q != '0 || mdu_hit;
    stall = !reset && hazard;
    pc_write = !stall;
    if_id_write = !stall;
    if_id_flush = !reset && branch_taken_id && !hazard;
    // the hold counter covers the cycles after the detecting one, so it loads LOAD_STALL-1
    ld_cnt_d = ld_cnt_q != '0 ? ld_cnt_q - 4'd1 : lu_hit ? 4'(LOAD_STALL - 1) : '0;
    mdu_cnt_d = mdu_start_ex ? 6'(MDU_LAT) : mdu_cnt_q != '0 ? mdu_cnt_q - 6'd1 : '0;
    cnt_d = stall && cnt_q != '1 ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt_q <= '0;
      mdu_cnt_q <= '0;
      cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      mdu_cnt_q <= mdu_cnt_d;
      cnt_q <= cnt_d;
    end
  end
  assign stall_cycles = cnt_q;
endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// tb_mips_hazard_ctrl: two configurations (LOAD_STALL=1/CNT_W=16 and LOAD_STALL=3/CNT_W=4) checked by vectors and a cycle-count model
module tb_mips_hazard_ctrl;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset, mem_read_ex, uses_rs_id, uses_rt_id, mdu_start_ex, mdu_use_id, branch_taken_id;
  logic [4:0] rt_ex, rs_id, rt_id;
  logic [1:0] pw, iw, st, fl, bz;
  logic [15:0] sc_a;
  logic [3:0] sc_b;
  mips_hazard_ctrl u_a (
    .clk(clk), .reset(reset), .mem_read_ex(mem_read_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .mdu_start_ex(mdu_start_ex), .mdu_use_id(mdu_use_id),
    .branch_taken_id(branch_taken_id), .pc_write(pw[0]), .if_id_write(iw[0]), .stall(st[0]),
    .if_id_flush(fl[0]), .mdu_busy(bz[0]), .stall_cycles(sc_a));
  mips_hazard_ctrl #(.LOAD_STALL(3), .MDU_LAT(4), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .mem_read_ex(mem_read_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id), .mdu_start_ex(mdu_start_ex), .mdu_use_id(mdu_use_id),
    .branch_taken_id(branch_taken_id), .pc_write(pw[1]), .if_id_write(iw[1]), .stall(st[1]),
    .if_id_flush(fl[1]), .mdu_busy(bz[1]), .stall_cycles(sc_b));

  typedef struct {
    logic mr; logic [4:0] rte, rs, rt; logic urs, urt, ms, mu, br;
    logic sa, sb, fa, fb, bsy;
  } vec_t;
  vec_t tbl[22];
  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  bit known = 0;
  int ld_until[2] = '{-1, -1};
  int done[2] = '{-1, -1};
  int cnt[2] = '{0, 0};
  int lat[2] = '{1, 3};
  int maxc[2] = '{65535, 15};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t v(input logic mr, input logic [4:0] rte, rs, rt, input logic urs, urt, ms, mu, br,
                             input logic sa, sb, fa, fb, bsy);
    vec_t r;
    r.mr = mr; r.rte = rte; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.ms = ms; r.mu = mu; r.br = br;
    r.sa = sa; r.sb = sb; r.fa = fa; r.fb = fb; r.bsy = bsy;
    return r;
  endfunction

  task automatic drive(input logic rst, mr, input logic [4:0] rte, rs, rt, input logic urs, urt, ms, mu, br);
    reset = rst; mem_read_ex = mr; rt_ex = rte; rs_id = rs; rt_id = rt;
    uses_rs_id = urs; uses_rt_id = urt; mdu_start_ex = ms; mdu_use_id = mu; branch_taken_id = br;
  endtask

  task automatic idle(input logic rst);
    drive(rst, 0, 0, 1, 2, 0, 0, 0, 0, 0);
  endtask

  // stall windows are tracked as absolute cycle numbers rather than counters
  task automatic model();
    bit lu, hold, busy, s;
    logic [31:0] got_sc;
    lu = mem_read_ex && rt_ex != 0 && ((uses_rs_id && rt_ex == rs_id) || (uses_rt_id && rt_ex == rt_id));
    for (int k = 0; k < 2; k++) begin
      hold = cyc <= ld_until[k];
      busy = cyc <= done[k];
      s = !reset && (lu || hold || (mdu_use_id && busy));
      check($sformatf("stall%0d", k), st[k], s);
      check($sformatf("pc_write%0d", k), pw[k], !s);
      check($sformatf("if_id_write%0d", k), iw[k], !s);
      check($sformatf("flush%0d", k), fl[k], !reset && branch_taken_id && !s);
      check($sformatf("mdu_busy%0d", k), bz[k], !reset && busy);
      got_sc = k ? 32'(sc_b) : 32'(sc_a);
      if (known) check($sformatf("stall_cycles%0d", k), got_sc, cnt[k]);
      if (reset) begin
        ld_until[k] = -1; done[k] = -1; cnt[k] = 0;
      end else begin
        if (lu && !hold) ld_until[k] = cyc + lat[k] - 1;
        if (mdu_start_ex) done[k] = cyc + 4;
        if (s && cnt[k] < maxc[k]) cnt[k]++;
      end
    end
    if (reset) known = 1;
    cyc++;
  endtask

  task automatic step();
    #2;
    model();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = v(1, 5, 5, 2, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[1]  = v(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[2]  = v(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[3]  = v(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = v(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = v(1, 7, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = v(1, 7, 1, 7, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[7]  = v(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[8]  = v(0, 0, 1, 2, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    tbl[9]  = v(0, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    tbl[10] = v(0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = v(0, 0, 1, 2, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1);
    tbl[12] = v(0, 0, 1, 2, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1);
    for (int i = 13; i < 17; i++) tbl[i] = v(0, 0, 1, 2, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1);
    tbl[17] = v(0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[18] = v(1, 9, 9, 2, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    tbl[19] = v(0, 0, 1, 2, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    tbl[20] = v(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[21] = v(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset must win over a live load-use hazard
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 3, 3, 0, 1, 0, 0, 0, 0);
      step();
    end

    for (int i = 0; i < 22; i++) begin
      drive(0, tbl[i].mr, tbl[i].rte, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].ms, tbl[i].mu, tbl[i].br);
      #1;
      check($sformatf("vec%0d stall_a", i), st[0], tbl[i].sa);
      check($sformatf("vec%0d stall_b", i), st[1], tbl[i].sb);
      check($sformatf("vec%0d pc_write_b", i), pw[1], !tbl[i].sb);
      check($sformatf("vec%0d flush_a", i), fl[0], tbl[i].fa);
      check($sformatf("vec%0d flush_b", i), fl[1], tbl[i].fb);
      check($sformatf("vec%0d busy", i), bz[0], tbl[i].bsy);
      if (i == 3) check("stall_cycles_a after first load", sc_a, 16'd1);
      step();
    end

    for (int i = 0; i < 22; i++) begin
      drive(0, 0, 0, 1, 2, 0, 0, 1, 1, 0);
      step();
    end
    idle(0);
    #1;
    check("saturated stall_cycles_b", sc_b, 4'd15);
    step();
    #1;
    check("saturated stall_cycles_b holds", sc_b, 4'd15);
    for (int i = 0; i < 5; i++) step();

    drive(0, 1, 5, 5, 2, 1, 0, 0, 0, 0);
    step();
    idle(1);
    step();
    idle(0);
    #1;
    check("post-reset stall_b", st[1], 1'b0);
    check("post-reset stall_cycles_a", sc_a, 16'd0);
    check("post-reset stall_cycles_b", sc_b, 4'd0);
    check("post-reset mdu_busy", bz[1], 1'b0);
    step();

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) == 0,
            $urandom_range(0, 1), $urandom_range(0, 3) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_hazard_ctrl.md
Name: mips_hazard_ctrl

Overview:
- Parametrised hazard/stall controller for the 5-stage MIPS pipeline; sits between ID and EX and drives PC, IF/ID and ID/EX bubble control.
- Extends plain load-use detection in four ways:
  - configurable multi-cycle load-use stall;
  - register-0 and unused-operand filtering;
  - multi-cycle multiply/divide (MDU) busy interlock;
  - taken-branch IF/ID flush.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5, register address width.
- LOAD_STALL, 1, bubble cycles per load-use hazard (1..15); covers slow data memory.
- MDU_LAT, 4, cycles the MDU stays busy after a start (1..63).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- mem_read_ex  in  1  EX instruction is a load
- rt_ex  in  REG_AW  load destination register in EX
- rs_id  in  REG_AW  ID source register rs
- rt_id  in  REG_AW  ID source register rt
- uses_rs_id  in  1  ID instruction actually reads rs
- uses_rt_id  in  1  ID instruction actually reads rt
- mdu_start_ex  in  1  mult/div entering EX this cycle (pulse)
- mdu_use_id  in  1  ID instruction is mfhi/mflo/mult/div
- branch_taken_id  in  1  branch/jump resolved taken in ID
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- stall  out  1  insert bubble into ID/EX (zero control bits)
- if_id_flush  out  1  clear IF/ID to NOP on next edge
- mdu_busy  out  1  MDU result not yet available
- stall_cycles  out  CNT_W  count of cycles with stall=1

Behaviour:
- Reset, synchronous, active-high, overriding all other inputs:
  - Counters ld_cnt, mdu_cnt and stall_cycles clear to 0.
  - While reset=1, outputs are forced to pc_write=1, if_id_write=1, stall=0, if_id_flush=0, mdu_busy=0.
  - Reset mid-stall aborts the stall; the first cycle after reset evaluates inputs fresh.
- Load-use hit (lu_hit, combinational) requires all of:
  - mem_read_ex=1;
  - rt_ex≠0;
  - (uses_rs_id && rt_ex==rs_id) || (uses_rt_id && rt_ex==rt_id).
- Load-use hold (ld_cnt, down-counter, width 4):
  - On lu_hit with ld_cnt==0, load ld_cnt=LOAD_STALL-1.
  - While ld_cnt>0, decrement each cycle.
  - Total stall length is exactly LOAD_STALL cycles.
  - A new lu_hit while ld_cnt>0 does not reload.
- MDU interlock (mdu_cnt, 6 bits):
  - mdu_start_ex=1 loads mdu_cnt=MDU_LAT, including when already busy (restart).
  - Otherwise decrement while >0.
  - mdu_busy = (mdu_cnt≠0), registered view.
  - mdu_hit = mdu_use_id && mdu_busy.
- Stall and enables:
  - stall = lu_hit || (ld_cnt≠0) || mdu_hit.
  - pc_write = if_id_write = ~stall.
- Flush:
  - if_id_flush = branch_taken_id && ~stall.
  - Stall has priority: a branch in ID waiting on an operand is not flushed until the stall clears.
  - pc_write stays 1 during a flush.
- Simultaneous lu_hit and mdu_hit produce a single stall; the stall ends when both conditions clear.
- stall_cycles increments on each cycle with stall=1 and saturates at 2^CNT_W-1 (no wrap).
- All outputs except mdu_busy and stall_cycles are combinational from inputs and registered state.
- Zero added latency on first-cycle detection.

Test Plan:
- Reset: assert reset 2 cycles with mem_read_ex=1, rt_ex=rs_id=3, uses_rs_id=1 -> pc_write=1, stall=0, stall_cycles=0 throughout.
- Load-use, LOAD_STALL=1: mem_read_ex=1, rt_ex=5, rs_id=5, uses_rs_id=1 for one cycle, then bubble (mem_read_ex=0) -> stall=1 for exactly 1 cycle, then 0; stall_cycles=1.
- Load-use, LOAD_STALL=3: same stimulus -> stall=1 for 3 consecutive cycles, pc_write=0 for the same 3 cycles. Repeat with rt_ex=0 -> no stall. Repeat with rt_ex=rt_id=7 and uses_rt_id=0 -> no stall.
- MDU, MDU_LAT=4: mdu_start_ex pulse at cycle 0, mdu_use_id=1 from cycle 1 -> mdu_busy=1 cycles 1-4, stall=1 cycles 1-4, released at cycle 5. Restart at cycle 2 -> busy extends through cycle 6.
- Branch priority: branch_taken_id=1 together with lu_hit -> if_id_flush=0, stall=1. Next cycle, hazard clear -> if_id_flush=1, stall=0, pc_write=1.
- Saturation, CNT_W=4: hold stall 20 cycles -> stall_cycles reaches 15 and stays 15. Reset mid-hold (LOAD_STALL=3, reset at 2nd stall cycle) -> stall=0 on the cycle after reset deasserts, counters 0.
